// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control unit.
//   pctrl_state_e         : control FSM states
//   STG_IF..STG_WB        : pipeline stage indices
//   *_MASK                : 8-bit stall/flush patterns, truncated by the
//                           top to the configured pipeline depth
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    BUSY       = 2'd2
  } pctrl_state_e;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int MAX_STAGES = 8;

  function automatic logic [MAX_STAGES-1:0] stage_bit(input int stg);
    return 8'd1 << stg;
  endfunction

  // Load-use: freeze IF/ID, bubble into EX
  localparam logic [MAX_STAGES-1:0] LU_STALL_MASK   = stage_bit(STG_IF) | stage_bit(STG_ID);
  localparam logic [MAX_STAGES-1:0] LU_FLUSH_MASK   = stage_bit(STG_EX);
  // Multi-cycle EX: freeze IF/ID/EX, bubble into MEM
  localparam logic [MAX_STAGES-1:0] BUSY_STALL_MASK = stage_bit(STG_IF) | stage_bit(STG_ID) |
                                                      stage_bit(STG_EX);
  localparam logic [MAX_STAGES-1:0] BUSY_FLUSH_MASK = stage_bit(STG_MEM);
  // Jump: kill the wrong-path instructions in ID and EX
  localparam logic [MAX_STAGES-1:0] JMP_FLUSH_MASK  = stage_bit(STG_ID) | stage_bit(STG_EX);

endpackage

// File: rtl/defines.sv
// Shared instruction-field widths and opcode encodings for the core.
// Macros: OpcodeWide, RegAddrBus, InstAddrBus, INST_TYPE_L.
`ifndef PIPE_DEFINES_SV
`define PIPE_DEFINES_SV

`define OpcodeWide   6:0
`define RegAddrBus   4:0
`define InstAddrBus  31:0

// Load instruction class opcode
`define INST_TYPE_L  7'b0000011

`endif

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Ports:
//   ex_opcode            opcode of the instruction in EX
//   ex_rd                destination register of the instruction in EX
//   id_rs1 / id_rs2      source registers of the instruction in ID
//   id_rs1_re/id_rs2_re  ID actually reads the corresponding source
//   hz                   1 when ID needs a value a load in EX has not produced yet
module hazard_detect (
  input  logic [`OpcodeWide] ex_opcode,
  input  logic [`RegAddrBus] ex_rd,
  input  logic [`RegAddrBus] id_rs1,
  input  logic [`RegAddrBus] id_rs2,
  input  logic               id_rs1_re,
  input  logic               id_rs2_re,
  output logic               hz
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_rs1_re && (id_rs1 == ex_rd);
  assign rs2_hit = id_rs2_re && (id_rs2 == ex_rd);

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign hz = (ex_opcode == `INST_TYPE_L) && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline control: load-use interlock, jump redirect/flush and
// multi-cycle EX hold for an NUM_STAGES-deep pipeline (0=IF .. 4=WB).
// Optional feature macro: PIPE_HAZARD_CTRL_PERF_EN enables saturating
// perf counters; without it the counter outputs are tied to zero.
// Ports:
//   clk, rst                 clock, async active-high reset
//   ex_opcode_i, ex_rd_i     instruction in EX
//   id_rs1_i, id_rs2_i       sources of the instruction in ID
//   id_rs1_re_i, id_rs2_re_i source read enables
//   jump_req_i, jump_addr_i  taken jump/branch resolved in EX and its target
//   ex_start_i, ex_done_i    multi-cycle EX op issue / result valid
//   stall_o[k]               stage-k register holds its value
//   flush_o[k]               register feeding stage k loads a bubble
//   hold_o                   any stall, to pc_reg
//   jump_o, jump_addr_o      PC redirect (target is 0 when not redirecting)
//   stall_cnt_o, flush_cnt_o perf counters (hold cycles, jump flushes)
//   dbg_state_o              current control state
// Handshake: there is no valid/ready pairing here; every output is a
// level valid for the current cycle, derived from the registered state
// and this cycle's inputs.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 5,   // 3..8
  parameter int unsigned LOAD_STALL_CYC = 1,   // 1..15
  parameter int unsigned CNT_W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [`OpcodeWide]    ex_opcode_i,
  input  logic [`RegAddrBus]    ex_rd_i,
  input  logic [`RegAddrBus]    id_rs1_i,
  input  logic [`RegAddrBus]    id_rs2_i,
  input  logic                  id_rs1_re_i,
  input  logic                  id_rs2_re_i,
  input  logic                  jump_req_i,
  input  logic [`InstAddrBus]   jump_addr_i,
  input  logic                  ex_start_i,
  input  logic                  ex_done_i,
  output logic [NUM_STAGES-1:0] stall_o,
  output logic [NUM_STAGES-1:0] flush_o,
  output logic                  hold_o,
  output logic                  jump_o,
  output logic [`InstAddrBus]   jump_addr_o,
  output logic [CNT_W-1:0]      stall_cnt_o,
  output logic [CNT_W-1:0]      flush_cnt_o,
  output pctrl_state_e          dbg_state_o
);

  // Patterns cut down to the configured depth; bits beyond it simply vanish
  localparam logic [NUM_STAGES-1:0] LU_STALL   = LU_STALL_MASK[NUM_STAGES-1:0];
  localparam logic [NUM_STAGES-1:0] LU_FLUSH   = LU_FLUSH_MASK[NUM_STAGES-1:0];
  localparam logic [NUM_STAGES-1:0] BUSY_STALL = BUSY_STALL_MASK[NUM_STAGES-1:0];
  localparam logic [NUM_STAGES-1:0] BUSY_FLUSH = BUSY_FLUSH_MASK[NUM_STAGES-1:0];
  localparam logic [NUM_STAGES-1:0] JMP_FLUSH  = JMP_FLUSH_MASK[NUM_STAGES-1:0];

  pctrl_state_e          state;
  logic [3:0]            load_cnt;
  logic                  hz;
  logic [NUM_STAGES-1:0] stall_v;
  logic [NUM_STAGES-1:0] flush_v;
  logic                  jump_v;

  hazard_detect u_hazard_detect (
    .ex_opcode (ex_opcode_i),
    .ex_rd     (ex_rd_i),
    .id_rs1    (id_rs1_i),
    .id_rs2    (id_rs2_i),
    .id_rs1_re (id_rs1_re_i),
    .id_rs2_re (id_rs2_re_i),
    .hz        (hz)
  );

  // Output decode. rst gates everything so a reset asserted mid-cycle
  // clears the outputs immediately instead of at the next edge.
  always_comb begin
    stall_v = '0;
    flush_v = '0;
    jump_v  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (ex_start_i) begin
            // start with done in the same cycle is a single-cycle op
            if (!ex_done_i) begin
              stall_v = BUSY_STALL;
              flush_v = BUSY_FLUSH;
            end
          end else if (jump_req_i) begin
            // the ID instruction is wrong-path, so its hazard is moot
            jump_v  = 1'b1;
            flush_v = JMP_FLUSH;
          end else if (hz) begin
            stall_v = LU_STALL;
            flush_v = LU_FLUSH;
          end
        end
        LOAD_STALL: begin
          if (jump_req_i) begin
            jump_v  = 1'b1;
            flush_v = JMP_FLUSH;
          end else begin
            stall_v = LU_STALL;
            flush_v = LU_FLUSH;
          end
        end
        BUSY: begin
          // result arrives: release in the same cycle; jumps are not
          // possible while EX is occupied, so jump_req_i is ignored
          if (!ex_done_i) begin
            stall_v = BUSY_STALL;
            flush_v = BUSY_FLUSH;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_o     = stall_v;
  assign flush_o     = flush_v;
  assign hold_o      = |stall_v;
  assign jump_o      = jump_v;
  assign jump_addr_o = jump_v ? jump_addr_i : '0;
  assign dbg_state_o = state;

  // Control FSM. load_cnt holds the stall cycles still owed after the
  // current one, so the hazard cycle itself counts toward the total.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      load_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_start_i) begin
            if (!ex_done_i) state <= BUSY;
          end else if (!jump_req_i && hz && (LOAD_STALL_CYC > 1)) begin
            state    <= LOAD_STALL;
            load_cnt <= 4'(LOAD_STALL_CYC - 1);
          end
        end
        LOAD_STALL: begin
          if (jump_req_i || (load_cnt == 4'd1)) begin
            state    <= IDLE;
            load_cnt <= '0;
          end else begin
            load_cnt <= load_cnt - 4'd1;
          end
        end
        BUSY: begin
          if (ex_done_i) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          load_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Saturating so a long run reads as "at least max" rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hold_o && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (jump_o && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt;
  assign flush_cnt_o = flush_cnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances share one stimulus stream
// (a: LOAD_STALL_CYC=1, CNT_W=4; b: LOAD_STALL_CYC=3, CNT_W=32).
// A directed sequence pins literal expectations, then random stimulus
// is checked each cycle against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_R = 7'b0110011;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [6:0]  ex_opcode;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic        re1, re2, jump_req, ex_start, ex_done;
  logic [31:0] jump_addr;

  logic [4:0]  stall_a, flush_a, stall_b, flush_b;
  logic        hold_a, jump_a, hold_b, jump_b;
  logic [31:0] jaddr_a, jaddr_b;
  logic [3:0]  scnt_a, fcnt_a;
  logic [31:0] scnt_b, fcnt_b;
  logic [1:0]  dbg_a, dbg_b;

  pipe_hazard_ctrl #(.NUM_STAGES(5), .LOAD_STALL_CYC(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .ex_opcode_i(ex_opcode), .ex_rd_i(ex_rd),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_re_i(re1), .id_rs2_re_i(re2),
    .jump_req_i(jump_req), .jump_addr_i(jump_addr), .ex_start_i(ex_start),
    .ex_done_i(ex_done), .stall_o(stall_a), .flush_o(flush_a), .hold_o(hold_a),
    .jump_o(jump_a), .jump_addr_o(jaddr_a), .stall_cnt_o(scnt_a),
    .flush_cnt_o(fcnt_a), .dbg_state_o(dbg_a)
  );

  pipe_hazard_ctrl #(.NUM_STAGES(5), .LOAD_STALL_CYC(3), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst), .ex_opcode_i(ex_opcode), .ex_rd_i(ex_rd),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rs1_re_i(re1), .id_rs2_re_i(re2),
    .jump_req_i(jump_req), .jump_addr_i(jump_addr), .ex_start_i(ex_start),
    .ex_done_i(ex_done), .stall_o(stall_b), .flush_o(flush_b), .hold_o(hold_b),
    .jump_o(jump_b), .jump_addr_o(jaddr_b), .stall_cnt_o(scnt_b),
    .flush_cnt_o(fcnt_b), .dbg_state_o(dbg_b)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: stall cycles still owed by a pending load-use hazard,
  // whether a multi-cycle op is outstanding, and perf totals.
  int     load_rem [2];
  bit     mul_busy [2];
  longint scnt_m   [2];
  longint fcnt_m   [2];
  int     lsc      [2] = '{1, 3};
  longint cmax     [2] = '{64'd15, 64'hFFFF_FFFF};

  always @(negedge clk) begin : compare
    logic        hz;
    logic [4:0]  es, ef, gs, gf;
    logic        ej, gh, gj;
    logic [31:0] ga, gsc, gfc;
    string       tag;
    hz = (ex_opcode == OP_L) && (ex_rd != 5'd0) &&
         ((re1 && (id_rs1 == ex_rd)) || (re2 && (id_rs2 == ex_rd)));
    for (int i = 0; i < 2; i++) begin
      es = 5'b0; ef = 5'b0; ej = 1'b0;
      if (i == 0) begin
        gs = stall_a; gf = flush_a; gh = hold_a; gj = jump_a; ga = jaddr_a;
        gsc = {28'd0, scnt_a}; gfc = {28'd0, fcnt_a}; tag = "a";
      end else begin
        gs = stall_b; gf = flush_b; gh = hold_b; gj = jump_b; ga = jaddr_b;
        gsc = scnt_b; gfc = fcnt_b; tag = "b";
      end
      if (rst) begin
        load_rem[i] = 0; mul_busy[i] = 1'b0; scnt_m[i] = 0; fcnt_m[i] = 0;
      end else if (mul_busy[i]) begin
        if (ex_done) mul_busy[i] = 1'b0;
        else begin es = 5'b00111; ef = 5'b01000; end
      end else if (load_rem[i] > 0) begin
        if (jump_req) begin ej = 1'b1; ef = 5'b00110; load_rem[i] = 0; end
        else begin es = 5'b00011; ef = 5'b00100; load_rem[i]--; end
      end else if (ex_start) begin
        if (!ex_done) begin es = 5'b00111; ef = 5'b01000; mul_busy[i] = 1'b1; end
      end else if (jump_req) begin
        ej = 1'b1; ef = 5'b00110;
      end else if (hz) begin
        es = 5'b00011; ef = 5'b00100; load_rem[i] = lsc[i] - 1;
      end
      chk({tag, "_m_stall"}, {27'd0, gs}, {27'd0, es});
      chk({tag, "_m_flush"}, {27'd0, gf}, {27'd0, ef});
      chk({tag, "_m_hold"},  {31'd0, gh}, {31'd0, (es != 5'b0)});
      chk({tag, "_m_jump"},  {31'd0, gj}, {31'd0, ej});
      if (ej) chk({tag, "_m_jaddr"}, ga, jump_addr);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
      chk({tag, "_m_scnt"}, gsc, scnt_m[i][31:0]);
      chk({tag, "_m_fcnt"}, gfc, fcnt_m[i][31:0]);
`else
      chk({tag, "_m_scnt"}, gsc, 32'd0);
      chk({tag, "_m_fcnt"}, gfc, 32'd0);
`endif
      if (!rst) begin
        if ((es != 5'b0) && (scnt_m[i] < cmax[i])) scnt_m[i]++;
        if (ej && (fcnt_m[i] < cmax[i])) fcnt_m[i]++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge; directed checks
  // follow 2 units later, well before the falling edge.
  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic r1, input logic r2, input logic jr,
                       input logic [31:0] ja, input logic st, input logic dn);
    @(posedge clk);
    #1;
    ex_opcode = op; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; re1 = r1; re2 = r2;
    jump_req = jr; jump_addr = ja; ex_start = st; ex_done = dn;
    #2;
  endtask

  task automatic idle();
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic load_hz();
    drive(OP_L, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  // Raise rst mid-cycle and require outputs to clear before any edge
  task automatic mid_cycle_reset(input string name);
    @(posedge clk);
    #1;
    ex_opcode = OP_R; ex_rd = 5'd0; re1 = 1'b0; re2 = 1'b0;
    jump_req = 1'b0; ex_start = 1'b0; ex_done = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk({name, "_stall_a"}, {27'd0, stall_a}, 32'd0);
    chk({name, "_stall_b"}, {27'd0, stall_b}, 32'd0);
    chk({name, "_flush_b"}, {27'd0, flush_b}, 32'd0);
    chk({name, "_hold_b"},  {31'd0, hold_b},  32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    rst = 1'b1;
    ex_opcode = 7'd0; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    re1 = 1'b0; re2 = 1'b0; jump_req = 1'b0; jump_addr = 32'd0;
    ex_start = 1'b0; ex_done = 1'b0;

    #3;
    chk("rst_stall_a", {27'd0, stall_a}, 32'd0);
    chk("rst_flush_a", {27'd0, flush_a}, 32'd0);
    chk("rst_hold_a",  {31'd0, hold_a},  32'd0);
    chk("rst_jump_b",  {31'd0, jump_b},  32'd0);
    chk("rst_scnt_b",  scnt_b,           32'd0);
    chk("rst_state_a", {30'd0, dbg_a},   {30'd0, pipe_ctrl_pkg::IDLE});
    chk("rst_state_b", {30'd0, dbg_b},   {30'd0, pipe_ctrl_pkg::IDLE});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // load-use hazard; a stalls one cycle, b three
    load_hz();
    chk("lu_stall_a", {27'd0, stall_a}, 32'b00011);
    chk("lu_flush_a", {27'd0, flush_a}, 32'b00100);
    chk("lu_hold_a",  {31'd0, hold_a},  32'd1);
    chk("lu_hold_b1", {31'd0, hold_b},  32'd1);
    idle();
    chk("lu_release_a", {31'd0, hold_a}, 32'd0);
    chk("lu_hold_b2",   {31'd0, hold_b}, 32'd1);
    idle();
    chk("lu_hold_b3",   {31'd0, hold_b}, 32'd1);
    idle();
    chk("lu_hold_b4",   {31'd0, hold_b}, 32'd0);

    // no hazard: load to x0, or rs1 not read
    drive(OP_L, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("rd0_hold_a", {31'd0, hold_a}, 32'd0);
    chk("rd0_hold_b", {31'd0, hold_b}, 32'd0);
    drive(OP_L, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("nore_hold_a", {31'd0, hold_a}, 32'd0);
    // rs2 path
    drive(OP_L, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    chk("rs2_stall_a", {27'd0, stall_a}, 32'b00011);
    repeat (3) idle();

    // jump in the second stall cycle aborts b's load stall
    load_hz();
    chk("ab_hold_b", {31'd0, hold_b}, 32'd1);
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
    chk("ab_jump_b",  {31'd0, jump_b},  32'd1);
    chk("ab_flush_b", {27'd0, flush_b}, 32'b00110);
    chk("ab_stall_b", {27'd0, stall_b}, 32'd0);
    chk("ab_jaddr_b", jaddr_b,          32'h40);
    idle();
    chk("ab_after_b", {31'd0, hold_b}, 32'd0);

    // jump and hazard together: jump wins
    drive(OP_L, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    chk("jh_jump_a",  {31'd0, jump_a},  32'd1);
    chk("jh_jaddr_a", jaddr_a,          32'h100);
    chk("jh_flush_a", {27'd0, flush_a}, 32'b00110);
    chk("jh_stall_a", {27'd0, stall_a}, 32'd0);
    chk("jh_stall_b", {27'd0, stall_b}, 32'd0);

    // multi-cycle op: four stall cycles, jump during BUSY ignored
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("mc_stall_a0", {27'd0, stall_a}, 32'b00111);
    chk("mc_flush_a0", {27'd0, flush_a}, 32'b01000);
    idle();
    chk("mc_stall_a1", {27'd0, stall_a}, 32'b00111);
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
    chk("mc_stall_a2", {27'd0, stall_a}, 32'b00111);
    chk("mc_jump_a2",  {31'd0, jump_a},  32'd0);
    idle();
    chk("mc_stall_a3", {27'd0, stall_a}, 32'b00111);
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    chk("mc_done_a", {27'd0, stall_a}, 32'd0);
    idle();
    chk("mc_after_a", {31'd0, hold_a}, 32'd0);

    // asynchronous reset inside LOAD_STALL, then inside BUSY
    load_hz();
    mid_cycle_reset("rst_ls");
    idle();
    chk("rst_ls_after_b", {31'd0, hold_b}, 32'd0);
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("rst_busy_pre_b", {27'd0, stall_b}, 32'b00111);
    mid_cycle_reset("rst_busy");
    idle();
    chk("rst_busy_after_a", {31'd0, hold_a}, 32'd0);

    // 20 stall cycles: a's 4-bit counter saturates
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    repeat (19) idle();
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    idle();
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk("perf_scnt_a", {28'd0, scnt_a}, 32'hF);
    chk("perf_scnt_b", scnt_b,          32'd20);
`else
    chk("perf_scnt_a", {28'd0, scnt_a}, 32'd0);
    chk("perf_scnt_b", scnt_b,          32'd0);
`endif
    chk("perf_fcnt_a", {28'd0, fcnt_a}, 32'd0);

    // randomized phase, small register space to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 99) == 0);
      ex_opcode = ($urandom_range(0, 1) == 1) ? OP_L : OP_R;
      ex_rd     = 5'($urandom_range(0, 3));
      id_rs1    = 5'($urandom_range(0, 3));
      id_rs2    = 5'($urandom_range(0, 3));
      re1       = 1'($urandom_range(0, 1));
      re2       = 1'($urandom_range(0, 1));
      jump_req  = ($urandom_range(0, 99) < 15);
      jump_addr = $urandom;
      ex_start  = ($urandom_range(0, 99) < 10);
      ex_done   = ($urandom_range(0, 99) < 30);
    end
    rst = 1'b0;
    repeat (3) idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin : watchdog
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
